// File: rtl/ahb_bus_arbiter.sv
// Registered round-robin AHB-Lite bus arbiter with burst/lock protection and
// parking on a default master. All outputs change only on hready=1 or reset.
module ahb_bus_arbiter #(
  parameter int MASTERS        = 2,
  parameter int MIDX_W         = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] hreq,
  input  logic [MASTERS-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  output logic [MASTERS-1:0] hgrant,
  output logic [MIDX_W-1:0]  hmaster,
  output logic [MIDX_W-1:0]  hmaster_data,
  output logic               hmastlock,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OWN   = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [MIDX_W-1:0] DEF_IDX = MIDX_W'(DEFAULT_MASTER);

  state_t              state_q, state_d;
  logic [MIDX_W-1:0]   ptr_q, ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MIDX_W-1:0]   master_d;
  logic                lock_d;
  logic                rearb;
  logic                found;
  logic [MIDX_W-1:0]   winner;
  logic                owner_req;
  logic                owner_lock;
  logic                fixed_burst;
  logic [3:0]          burst_last;

  assign fsm_state   = state_q;
  assign owner_req   = hreq[hmaster];
  assign owner_lock  = hlock[hmaster];
  assign fixed_burst = |hburst[2:1];

  always_comb begin
    burst_last = 4'd0;
    case (hburst[2:1])
      2'd1:    burst_last = 4'd3;
      2'd2:    burst_last = 4'd7;
      2'd3:    burst_last = 4'd15;
      default: burst_last = 4'd0;
    endcase
  end

  // Search starts just after the last winner, so the last winner is seen last.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    for (int i = 1; i <= MASTERS; i++) begin
      if (!found && hreq[MIDX_W'((int'(ptr_q) + i) % MASTERS)]) begin
        found  = 1'b1;
        winner = MIDX_W'((int'(ptr_q) + i) % MASTERS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rearb    = 1'b0;
    master_d = hmaster;
    lock_d   = hmastlock;
    case (state_q)
      PARK: rearb = 1'b1;
      OWN: begin
        if (htrans == TR_IDLE) begin
          rearb = 1'b1;
        end else if (htrans == TR_BUSY) begin
          rearb = 1'b0;
        end else if (htrans == TR_NONSEQ && fixed_burst) begin
          cnt_d   = burst_last;
          state_d = BURST;
        end else if (htrans == TR_NONSEQ && hburst == 3'd0) begin
          rearb = 1'b1;
        end else if (!owner_req) begin
          rearb = 1'b1;
        end
      end
      BURST: begin
        if (htrans == TR_IDLE) begin
          rearb = 1'b1;
          cnt_d = 4'd0;
        end else if (htrans == TR_SEQ) begin
          // The beat seen with counter=1 is the last address phase.
          if (cnt_q <= 4'd1) begin
            rearb = 1'b1;
            cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      if (owner_lock) begin
        master_d = hmaster;
        state_d  = OWN;
      end else if (found) begin
        master_d = winner;
        ptr_d    = winner;
        state_d  = OWN;
      end else begin
        master_d = DEF_IDX;
        state_d  = PARK;
      end
      lock_d = hlock[master_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PARK;
      ptr_q        <= DEF_IDX;
      cnt_q        <= 4'd0;
      hgrant       <= MASTERS'(1) << DEF_IDX;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      hmastlock    <= 1'b0;
    end else if (hready) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      hgrant       <= MASTERS'(1) << master_d;
      hmaster      <= master_d;
      hmaster_data <= hmaster;
      hmastlock    <= lock_d;
    end
  end

endmodule
